// File: rtl/clk_div_pkg.sv
// Shared types and constants for the multi-channel clock divider.
package clk_div_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDiv,
        StByp
    } clk_div_state_e;

    // Ratios at or below this value select the reference-clock bypass path.
    localparam int unsigned BYP_MAX_RATIO = 1;

endpackage

// File: rtl/clk_div_ch.sv
// One divider channel: IDLE/DIV/BYP FSM, period counter and output mux.
// Ratio and enable are sampled only at period boundaries, so no runt pulses.
module clk_div_ch
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W = 8
) (
    input  logic             i_ref_clk,
    input  logic             i_rst_n,
    input  logic             i_clk_en,
    input  logic [DIV_W-1:0] i_div_ratio,
    output logic             o_div_clk,
    output logic             o_div_tick,
    output logic             o_active
);

    localparam logic [DIV_W-1:0] BYP_MAX = DIV_W'(BYP_MAX_RATIO);

    clk_div_state_e   state_q;
    logic [DIV_W-1:0] act_ratio_q;
    logic [DIV_W-1:0] cnt_q;
    logic             div_q;
    logic             tick_q;

    logic [DIV_W:0]   cnt_inc;
    logic [DIV_W:0]   half;
    logic             at_boundary;
    logic             ratio_ok;

    // One extra bit keeps (N+1)>>1 exact for N = 2^DIV_W-1.
    assign cnt_inc     = {1'b0, cnt_q} + (DIV_W+1)'(1);
    assign half        = ({1'b0, act_ratio_q} + (DIV_W+1)'(1)) >> 1;
    assign at_boundary = (cnt_q == act_ratio_q - DIV_W'(1));
    assign ratio_ok    = (i_div_ratio > BYP_MAX);

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= StIdle;
            act_ratio_q <= '0;
            cnt_q       <= '0;
            div_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            case (state_q)
                StDiv: begin
                    if (at_boundary) begin
                        cnt_q <= '0;
                        if (!i_clk_en) begin
                            state_q <= StIdle;
                            div_q   <= 1'b0;
                            tick_q  <= 1'b0;
                        end else if (ratio_ok) begin
                            act_ratio_q <= i_div_ratio;
                            div_q       <= 1'b1;
                            tick_q      <= 1'b1;
                        end else begin
                            state_q <= StByp;
                            div_q   <= 1'b0;
                            tick_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q  <= cnt_inc[DIV_W-1:0];
                        div_q  <= (cnt_inc < half);
                        tick_q <= 1'b0;
                    end
                end
                StIdle, StByp: begin
                    cnt_q  <= '0;
                    div_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (!i_clk_en) begin
                        state_q <= StIdle;
                    end else if (ratio_ok) begin
                        state_q     <= StDiv;
                        act_ratio_q <= i_div_ratio;
                        div_q       <= 1'b1;
                        tick_q      <= 1'b1;
                    end else begin
                        state_q <= StByp;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    div_q   <= 1'b0;
                    tick_q  <= 1'b0;
                end
            endcase
        end
    end

    // Bypass passes the reference clock straight through.
    assign o_div_clk  = (state_q == StByp) ? i_ref_clk : div_q;
    assign o_div_tick = (state_q == StByp) | tick_q;
    assign o_active   = (state_q != StIdle);

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel integer clock divider: NUM_CH independent clk_div_ch instances.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned NUM_CH = 2
) (
    input  logic                    i_ref_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_CH-1:0]       i_clk_en,
    input  logic [NUM_CH*DIV_W-1:0] i_div_ratio,
    output logic [NUM_CH-1:0]       o_div_clk,
    output logic [NUM_CH-1:0]       o_div_tick,
    output logic [NUM_CH-1:0]       o_active
);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        clk_div_ch #(
            .DIV_W(DIV_W)
        ) u_ch (
            .i_ref_clk  (i_ref_clk),
            .i_rst_n    (i_rst_n),
            .i_clk_en   (i_clk_en[c]),
            .i_div_ratio(i_div_ratio[c*DIV_W +: DIV_W]),
            .o_div_clk  (o_div_clk[c]),
            .o_div_tick (o_div_tick[c]),
            .o_active   (o_active[c])
        );
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (DIV_W=8, NUM_CH=2).
module tb_clk_div_multi;

    logic        ref_clk;
    logic        rst_n;
    logic [1:0]  clk_en;
    logic [15:0] div_ratio;
    logic [1:0]  div_clk;
    logic [1:0]  div_tick;
    logic [1:0]  active;

    int checks;
    int errors;

    clk_div_multi #(
        .DIV_W (8),
        .NUM_CH(2)
    ) dut (
        .i_ref_clk  (ref_clk),
        .i_rst_n    (rst_n),
        .i_clk_en   (clk_en),
        .i_div_ratio(div_ratio),
        .o_div_clk  (div_clk),
        .o_div_tick (div_tick),
        .o_active   (active)
    );

    initial ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    task automatic step();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Patterns are MSB-first: the first cycle checked is bit n-1.
    task automatic run_pat(input string tag, input int n, input logic [63:0] clk_bits,
                           input logic [63:0] tick_bits);
        for (int i = 0; i < n; i++) begin
            step();
            chk($sformatf("%s_clk%0d", tag, i), {7'd0, div_clk[0]}, {7'd0, clk_bits[n-1-i]});
            chk($sformatf("%s_tick%0d", tag, i), {7'd0, div_tick[0]}, {7'd0, tick_bits[n-1-i]});
        end
    endtask

    initial begin
        logic [63:0] p0_clk, p0_tick, p1_clk, p1_tick;
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b1;
        clk_en    = 2'b00;
        div_ratio = 16'h0000;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_clk", {6'd0, div_clk}, 8'h00);
        chk("rst_tick", {6'd0, div_tick}, 8'h00);
        chk("rst_active", {6'd0, active}, 8'h00);
        step();
        step();
        chk("rst_hold_clk", {6'd0, div_clk}, 8'h00);
        rst_n = 1'b1;

        // N=4: 2 high / 2 low
        clk_en[0]       = 1'b1;
        div_ratio[7:0]  = 8'd4;
        run_pat("n4", 8, 64'b11001100, 64'b10001000);
        chk("n4_active", {6'd0, active}, 8'h01);

        // N=5: 3 high / 2 low (switch lands on the boundary just reached)
        div_ratio[7:0] = 8'd5;
        run_pat("n5", 10, 64'b1110011100, 64'b1000010000);

        // N=2: toggles every cycle
        div_ratio[7:0] = 8'd2;
        run_pat("n2", 6, 64'b101010, 64'b101010);

        // N=255: 128 high / 127 low
        div_ratio[7:0] = 8'd255;
        for (int i = 0; i < 255; i++) begin
            step();
            chk($sformatf("n255_clk%0d", i), {7'd0, div_clk[0]}, {7'd0, (i < 128)});
            chk($sformatf("n255_tick%0d", i), {7'd0, div_tick[0]}, {7'd0, (i == 0)});
        end

        // Ratio 4 -> 7 written at cnt=1: old period finishes, then 4 high / 3 low
        div_ratio[7:0] = 8'd4;
        run_pat("mid_a", 2, 64'b11, 64'b10);
        div_ratio[7:0] = 8'd7;
        run_pat("mid_b", 16, 64'b0011110001111000, 64'b0010000001000000);

        // N=6, enable dropped at cnt=2: period completes, then idle
        div_ratio[7:0] = 8'd6;
        run_pat("dis_a", 3, 64'b111, 64'b100);
        clk_en[0] = 1'b0;
        run_pat("dis_b", 3, 64'b000, 64'b000);
        chk("dis_active_last", {6'd0, active}, 8'h01);
        step();
        chk("dis_idle_clk", {7'd0, div_clk[0]}, 8'h00);
        chk("dis_idle_tick", {7'd0, div_tick[0]}, 8'h00);
        chk("dis_idle_active", {6'd0, active}, 8'h00);
        clk_en[0] = 1'b1;
        step();
        chk("reen_clk", {7'd0, div_clk[0]}, 8'h01);
        chk("reen_tick", {7'd0, div_tick[0]}, 8'h01);
        chk("reen_active", {6'd0, active}, 8'h01);
        run_pat("reen", 5, 64'b11000, 64'b00000);

        // N=1: bypass, output follows the reference clock
        div_ratio[7:0] = 8'd1;
        step();
        chk("byp_clk_hi0", {7'd0, div_clk[0]}, 8'h01);
        chk("byp_tick0", {7'd0, div_tick[0]}, 8'h01);
        chk("byp_active", {6'd0, active}, 8'h01);
        #5;
        chk("byp_clk_lo0", {7'd0, div_clk[0]}, 8'h00);
        chk("byp_tick_lo0", {7'd0, div_tick[0]}, 8'h01);
        step();
        chk("byp_clk_hi1", {7'd0, div_clk[0]}, 8'h01);
        #5;
        chk("byp_clk_lo1", {7'd0, div_clk[0]}, 8'h00);
        div_ratio[7:0] = 8'd3;
        run_pat("byp_n3", 6, 64'b110110, 64'b100100);

        // ch0 N=2 and ch1 N=9 together, reset pulsed in ch1 high phase
        div_ratio = {8'd9, 8'd2};
        clk_en    = 2'b11;
        p0_clk    = 64'b10101010101;
        p0_tick   = 64'b10101010101;
        p1_clk    = 64'b11111000011;
        p1_tick   = 64'b10000000010;
        for (int i = 0; i < 11; i++) begin
            step();
            chk($sformatf("dual_c0_clk%0d", i), {7'd0, div_clk[0]}, {7'd0, p0_clk[10-i]});
            chk($sformatf("dual_c0_tick%0d", i), {7'd0, div_tick[0]}, {7'd0, p0_tick[10-i]});
            chk($sformatf("dual_c1_clk%0d", i), {7'd0, div_clk[1]}, {7'd0, p1_clk[10-i]});
            chk($sformatf("dual_c1_tick%0d", i), {7'd0, div_tick[1]}, {7'd0, p1_tick[10-i]});
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_clk", {6'd0, div_clk}, 8'h00);
        chk("arst_tick", {6'd0, div_tick}, 8'h00);
        chk("arst_active", {6'd0, active}, 8'h00);
        step();
        chk("arst_hold_clk", {6'd0, div_clk}, 8'h00);
        chk("arst_hold_active", {6'd0, active}, 8'h00);
        rst_n   = 1'b1;
        p0_clk  = 64'b1010;
        p0_tick = 64'b1010;
        p1_clk  = 64'b1111;
        p1_tick = 64'b1000;
        for (int i = 0; i < 4; i++) begin
            step();
            chk($sformatf("post_c0_clk%0d", i), {7'd0, div_clk[0]}, {7'd0, p0_clk[3-i]});
            chk($sformatf("post_c0_tick%0d", i), {7'd0, div_tick[0]}, {7'd0, p0_tick[3-i]});
            chk($sformatf("post_c1_clk%0d", i), {7'd0, div_clk[1]}, {7'd0, p1_clk[3-i]});
            chk($sformatf("post_c1_tick%0d", i), {7'd0, div_tick[1]}, {7'd0, p1_tick[3-i]});
        end
        chk("post_active", {6'd0, active}, 8'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
